// File: rtl/fetch_unit.sv
// Dual-issue fetch stage: owns the PC, issues 8-byte requests, buffers responses in a
// credit-managed FIFO and hands {inst_a, inst_b, pc_a, pc_b} to decode. FETCH_PERF_EN adds perf counters.
package fetch_pkg;
  typedef struct packed {
    logic [31:0] inst_a;
    logic [31:0] inst_b;
    logic [31:0] pc_a;
    logic [31:0] pc_b;
  } fetchStruct;
endpackage

// Handshakes: a transfer happens on a clock edge where valid && ready are both high;
// valid never depends on ready. Responses have no ready: credits guarantee a FIFO slot.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [63:0] imem_rsp_data,
  output fetchStruct  fd_reg,
  output logic        fd_valid,
  input  logic        fd_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  fetchStruct    buf_q [FIFO_DEPTH];

  logic          req_fire, rsp_fire, push, pop;
  logic [CW:0]   credit_used;
  fetchStruct    push_entry;
  logic [31:0]   redirect_base;
  logic          unused_redirect_lsb;

  assign redirect_base       = {redirect_pc[31:3], 3'b000};
  assign unused_redirect_lsb = ^redirect_pc[2:0];

  // Outstanding requests plus buffered pairs may never exceed the FIFO size.
  assign credit_used    = {1'b0, out_q} + {1'b0, count_q};
  assign imem_req_valid = !reset && !redirect_valid &&
                          (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid;
  assign fd_valid = (count_q != '0) && !redirect_valid;
  assign fd_reg   = buf_q[rd_ptr_q];
  assign pop      = fd_valid && fd_ready;
  assign push     = rsp_fire && (drop_q == '0) && !redirect_valid;

  assign push_entry = '{inst_a: imem_rsp_data[31:0], inst_b: imem_rsp_data[63:32],
                        pc_a: rsp_pc_q, pc_b: rsp_pc_q + 32'd4};

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      pc_d     = redirect_base;
      rsp_pc_d = redirect_base;
      out_d    = out_q - CW'(rsp_fire);
      drop_d   = out_q - CW'(rsp_fire);
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (req_fire) pc_d = pc_q + 32'd8;
      out_d = out_q + CW'(req_fire) - CW'(rsp_fire);
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd8;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) buf_q[wr_ptr_q] <= push_entry;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_q, perf_redir_q;

  assign perf_stall_cnt    = perf_stall_q;
  assign perf_redirect_cnt = perf_redir_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_redir_q <= '0;
    end else begin
      if (fd_valid && !fd_ready && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_valid && (perf_redir_q != '1)) perf_redir_q <= perf_redir_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with programmable latency,
// expected-pair queue filled by the stimulus and drained by an independent monitor.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [63:0] imem_rsp_data;
  fetchStruct  fd_reg;
  logic        fd_valid;
  logic        fd_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  int fire_cnt = 0;
  logic [127:0] exp_q[$];
  logic [31:0]  mq_addr[$];
  int           mq_due[$];

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .fd_reg(fd_reg), .fd_valid(fd_valid), .fd_ready(fd_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model (drives at negedge) ----------------
  always @(negedge clk) begin
    logic [31:0] a;
    if (reset) begin
      mq_addr.delete();
      mq_due.delete();
      imem_rsp_valid = 1'b0;
      fire_cnt = 0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        a = mq_addr.pop_front();
        void'(mq_due.pop_front());
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = {~(a + 32'd4), ~a};
      end
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + mem_lat);
        fire_cnt++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pa, input logic [31:0] pb);
    exp_q.push_back({~pa, ~pb, pa, pb});
  endtask

  always @(negedge clk) begin
    if (!reset && fd_valid && fd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fd_pair: unexpected pop of %h", fd_reg);
      end else begin
        check("fd_pair", fd_reg, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    fd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    int got = 0;
    int budget = 100;
    fd_ready = 1'b1;
    #1;
    while (got < n && budget > 0) begin
      if (fd_valid) got++;
      next_cycle();
      budget--;
    end
    fd_ready = 1'b0;
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pairs expected %0d", got, n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    imem_req_ready = 1'b1;
    fd_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // Reset state, back-to-back fetch, credit stall with fd_ready low
    mem_lat = 1;
    do_reset();
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_fd_valid", fd_valid, 1'b0);
    check("rst_fd_reg", fd_reg, 128'd0);
    reset = 1'b0;
    #1;
    check("req_c0", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
    check("fdv_c0", fd_valid, 1'b0);
    next_cycle();
    check("req_c1", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8});
    check("fdv_c1", fd_valid, 1'b0);
    next_cycle();
    check("req_c2", {imem_req_valid, imem_req_addr}, {1'b1, 32'h10});
    check("fdv_c2", fd_valid, 1'b1);
    repeat (8) next_cycle();
    check("stall_fires", fire_cnt, 4);
    check("stall_req_valid", imem_req_valid, 1'b0);
    check("stall_fd_valid", fd_valid, 1'b1);
    push_exp(32'h00, 32'h04);
    push_exp(32'h08, 32'h0C);
    push_exp(32'h10, 32'h14);
    push_exp(32'h18, 32'h1C);
    drain(4);

    // Redirect with two responses in flight at latency 3
    mem_lat = 3;
    do_reset();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h104;
    #1;
    check("redir_req_valid", imem_req_valid, 1'b0);
    next_cycle();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    check("redir_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h100});
    push_exp(32'h100, 32'h104);
    drain(1);

    // Redirect coinciding with a response and a would-be pop
    mem_lat = 2;
    do_reset();
    reset = 1'b0;
    repeat (3) next_cycle();
    fd_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    #1;
    check("coll_fd_valid", fd_valid, 1'b0);
    check("coll_rsp_valid", imem_rsp_valid, 1'b1);
    next_cycle();
    fd_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("coll_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h200});
    push_exp(32'h200, 32'h204);
    drain(1);

    // PC wrap at the top of the address space
    mem_lat = 1;
    do_reset();
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("wrap_req0", {imem_req_valid, imem_req_addr}, {1'b1, 32'hFFFF_FFF8});
    next_cycle();
    check("wrap_req1", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
    push_exp(32'hFFFF_FFF8, 32'hFFFF_FFFC);
    push_exp(32'h0000_0000, 32'h0000_0004);
    drain(2);

`ifdef FETCH_PERF_EN
    // Five stall cycles (2..6), then two redirect cycles
    mem_lat = 1;
    do_reset();
    reset = 1'b0;
    repeat (7) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    next_cycle();
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("perf_stall", perf_stall_cnt, 32'd5);
    check("perf_redirect", perf_redirect_cnt, 32'd2);
    do_reset();
    check("perf_stall_rst", perf_stall_cnt, 32'd0);
    check("perf_redirect_rst", perf_redirect_cnt, 32'd0);
    reset = 1'b0;
`endif

    next_cycle();
    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
